// File: rtl/unified_mem_responder.sv
// rtl/unified_mem_responder.sv - fetch/data responder over one synchronous RAM
// Round-robin arbitration, RV32 load/store sizing, halfword-aligned split fetch, error flagging.
module unified_mem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int DATA_BASE   = 48,
  parameter int LATENCY     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [2:0]  LAT   = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rr_data_q, rr_data_d;
  logic          is_d_q, is_d_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          split_q, split_d;
  logic [15:0]   half_q, half_d;
  logic          if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          if_err_q, if_err_d;
  logic          d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          d_err_q, d_err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_rdata;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_data;

  logic [31:0]   ea;
  logic [32:0]   if_next_word;
  logic          d_f3_ok, d_misalign, d_oor, d_bad, if_bad;
  logic          grant_if, grant_d;
  logic [31:0]   ld_shift, ld_data;

  // Request decode and arbitration, evaluated only while IDLE.
  always_comb begin
    ea           = d_addr + 32'(DATA_BASE);
    if (d_we) d_f3_ok = (d_funct3 == 3'b000) || (d_funct3 == 3'b001) || (d_funct3 == 3'b010);
    else      d_f3_ok = (d_funct3[1:0] != 2'b11) && (d_funct3 != 3'b110);
    d_misalign   = ((d_funct3[1:0] == 2'b01) && ea[0]) ||
                   ((d_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    d_oor        = {1'b0, ea} >= BYTES;
    d_bad        = !d_f3_ok || d_misalign || d_oor;
    if_next_word = {1'b0, if_addr[31:2], 2'b00} + 33'd4;
    if_bad       = if_addr[0] || ({1'b0, if_addr} >= BYTES) || (if_addr[1] && (if_next_word >= BYTES));
    grant_if     = if_req_valid && (!d_req_valid || rr_data_q);
    grant_d      = d_req_valid && (!if_req_valid || !rr_data_q);
  end

  assign if_req_ready = rst && (state_q == IDLE) && grant_if;
  assign d_req_ready  = rst && (state_q == IDLE) && grant_d;

  always_comb begin
    ld_shift = ram_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_data_d      = rr_data_q;
    is_d_d         = is_d_q;
    addr_d         = addr_q;
    we_d           = we_q;
    f3_d           = f3_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    split_d        = split_q;
    half_d         = half_q;
    if_rsp_valid_d = 1'b0;
    if_rdata_d     = if_rdata_q;
    if_err_d       = if_err_q;
    d_rsp_valid_d  = 1'b0;
    d_rdata_d      = d_rdata_q;
    d_err_d        = d_err_q;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    ram_idx        = addr_q[AW+1:2];
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (grant_if) begin
          is_d_d    = 1'b0;
          addr_d    = if_addr[AW+1:0];
          err_d     = if_bad;
          split_d   = if_addr[1];
          rr_data_d = 1'b0;
          state_d   = if_bad ? RESP : ACC1;
        end else if (grant_d) begin
          is_d_d    = 1'b1;
          addr_d    = ea[AW+1:0];
          we_d      = d_we;
          f3_d      = d_funct3;
          wdata_d   = d_wdata;
          err_d     = d_bad;
          split_d   = 1'b0;
          rr_data_d = 1'b1;
          state_d   = d_bad ? RESP : ACC1;
        end
      end
      ACC1: begin
        if (cnt_q == LAT) begin
          cnt_d   = 3'd0;
          ram_we  = is_d_q && we_q;
          ram_re  = !(is_d_q && we_q);
          state_d = (!is_d_q && split_q) ? ACC2 : RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ACC2: begin
        // Word N is still in ram_rdata here; keep its upper half before N+1 overwrites it.
        if (cnt_q == LAT) begin
          cnt_d   = 3'd0;
          ram_re  = 1'b1;
          ram_idx = addr_q[AW+1:2] + AW'(1);
          half_d  = ram_rdata[31:16];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (is_d_q) begin
          d_rsp_valid_d = 1'b1;
          d_err_d       = err_q;
          d_rdata_d     = (err_q || we_q) ? 32'd0 : ld_data;
        end else begin
          if_rsp_valid_d = 1'b1;
          if_err_d       = err_q;
          if (err_q)        if_rdata_d = 32'd0;
          else if (split_q) if_rdata_d = {ram_rdata[15:0], half_q};
          else              if_rdata_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      rr_data_q      <= 1'b1;
      is_d_q         <= 1'b0;
      addr_q         <= '0;
      we_q           <= 1'b0;
      f3_q           <= 3'd0;
      wdata_q        <= 32'd0;
      err_q          <= 1'b0;
      split_q        <= 1'b0;
      half_q         <= 16'd0;
      if_rsp_valid_q <= 1'b0;
      if_rdata_q     <= 32'd0;
      if_err_q       <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      d_rdata_q      <= 32'd0;
      d_err_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_data_q      <= rr_data_d;
      is_d_q         <= is_d_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      f3_q           <= f3_d;
      wdata_q        <= wdata_d;
      err_q          <= err_d;
      split_q        <= split_d;
      half_q         <= half_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rdata_q     <= if_rdata_d;
      if_err_q       <= if_err_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rdata_q      <= d_rdata_d;
      d_err_q        <= d_err_d;
    end
  end

  // RAM array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[ram_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
    if (ram_re) ram_rdata <= mem[ram_idx];
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rdata     = if_rdata_q;
  assign if_err       = if_err_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rdata      = d_rdata_q;
  assign d_err        = d_err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// tb/tb_unified_mem_responder.sv - randomized self-checking bench for unified_mem_responder
// Two instances: LATENCY=0 (u0) and LATENCY=3 (u3), selected by sel.
module tb_unified_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        if_v, d_v, d_we;
  logic [2:0]  d_f3;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_rdy0, if_rv0, if_er0, d_rdy0, d_rv0, d_er0;
  logic [31:0] if_rd0, d_rd0;
  logic        if_rdy3, if_rv3, if_er3, d_rdy3, d_rv3, d_er3;
  logic [31:0] if_rd3, d_rd3;
  logic        if_rdy, if_rv, if_er, d_rdy, d_rv, d_er;
  logic [31:0] if_rd, d_rd;

  int total = 0;
  int bad = 0;
  logic [7:0] mm [0:16383];

  always #5 clk = ~clk;

  unified_mem_responder #(.DEPTH_WORDS(4096), .DATA_BASE(48), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst_n),
    .if_req_valid(if_v && !sel), .if_req_ready(if_rdy0), .if_addr(if_addr),
    .if_rsp_valid(if_rv0), .if_rdata(if_rd0), .if_err(if_er0),
    .d_req_valid(d_v && !sel), .d_req_ready(d_rdy0), .d_we(d_we), .d_funct3(d_f3),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rv0), .d_rdata(d_rd0), .d_err(d_er0)
  );

  unified_mem_responder #(.DEPTH_WORDS(4096), .DATA_BASE(48), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst_n),
    .if_req_valid(if_v && sel), .if_req_ready(if_rdy3), .if_addr(if_addr),
    .if_rsp_valid(if_rv3), .if_rdata(if_rd3), .if_err(if_er3),
    .d_req_valid(d_v && sel), .d_req_ready(d_rdy3), .d_we(d_we), .d_funct3(d_f3),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rv3), .d_rdata(d_rd3), .d_err(d_er3)
  );

  assign if_rdy = sel ? if_rdy3 : if_rdy0;
  assign if_rv  = sel ? if_rv3  : if_rv0;
  assign if_rd  = sel ? if_rd3  : if_rd0;
  assign if_er  = sel ? if_er3  : if_er0;
  assign d_rdy  = sel ? d_rdy3  : d_rdy0;
  assign d_rv   = sel ? d_rv3   : d_rv0;
  assign d_rd   = sel ? d_rd3   : d_rd0;
  assign d_er   = sel ? d_er3   : d_er0;

  // ---------------- reference model (byte-addressed memory) ----------------
  task automatic m_data(input logic we, input logic [2:0] f3, input logic [31:0] ea,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size;
    bit legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    size  = 1 << f3[1:0];
    er    = !legal || ((ea % size) != 0) || (ea >= 32'd16384);
    rd    = 32'd0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) mm[ea + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mm[ea + i];
      if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
    end
  endtask

  task automatic m_fetch(input logic [31:0] a, input int lat_extra,
                         output logic [31:0] rd, output logic er, output int lat);
    er = a[0] || ((longint'(a) + 3) >= 16384);
    if (er) begin
      rd = 32'd0; lat = 1;
    end else begin
      rd  = {mm[a + 3], mm[a + 2], mm[a + 1], mm[a]};
      lat = a[1] ? (3 + 2*lat_extra) : (2 + lat_extra);
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic d_op(input logic we, input logic [2:0] f3, input logic [31:0] ea,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    d_we = we; d_f3 = f3; d_addr = ea - 32'd48; d_wdata = wd; d_v = 1'b1;
    #1;
    n = 0;
    while (!d_rdy && n < 40) begin @(negedge clk); #1; n++; end
    rd = 32'd0; er = 1'b0; lat = -1;
    total++;
    if (!d_rdy) begin
      bad++;
      $display("FAIL d_accept: ready never rose, ea=%h", ea);
      d_v = 1'b0;
      return;
    end
    @(posedge clk); #1; d_v = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (d_rv) begin lat = k; rd = d_rd; er = d_er; return; end
    end
    bad++;
    $display("FAIL d_rsp: no response, ea=%h", ea);
  endtask

  task automatic f_op(input logic [31:0] a, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    if_addr = a; if_v = 1'b1;
    #1;
    n = 0;
    while (!if_rdy && n < 40) begin @(negedge clk); #1; n++; end
    rd = 32'd0; er = 1'b0; lat = -1;
    total++;
    if (!if_rdy) begin
      bad++;
      $display("FAIL if_accept: ready never rose, addr=%h", a);
      if_v = 1'b0;
      return;
    end
    @(posedge clk); #1; if_v = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if_rv) begin lat = k; rd = if_rd; er = if_er; return; end
    end
    bad++;
    $display("FAIL if_rsp: no response, addr=%h", a);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; sel = 1'b0; if_v = 1'b1; d_v = 1'b1;
    d_we = 1'b0; d_f3 = 3'd2; if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({if_rdy0, if_rv0, if_er0, d_rdy0, d_rv0, d_er0} !== 6'b0) begin
      bad++; $display("FAIL reset_u0_ctl: got %b want 000000", {if_rdy0, if_rv0, if_er0, d_rdy0, d_rv0, d_er0});
    end
    total++;
    if ({if_rdy3, if_rv3, if_er3, d_rdy3, d_rv3, d_er3} !== 6'b0) begin
      bad++; $display("FAIL reset_u3_ctl: got %b want 000000", {if_rdy3, if_rv3, if_er3, d_rdy3, d_rv3, d_er3});
    end
    total++;
    if ({if_rd0, d_rd0, if_rd3, d_rd3} !== 128'd0) begin
      bad++; $display("FAIL reset_rdata: got %h %h %h %h want 0", if_rd0, d_rd0, if_rd3, d_rd3);
    end
    if_v = 1'b0; d_v = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_spec_vectors;
    logic [31:0] rd, mrd; logic er, mer; int lat;
    sel = 1'b0;
    m_data(1'b1, 3'd2, 32'h100, 32'h8765_43A1, mrd, mer);
    d_op(1'b1, 3'd2, 32'h100, 32'h8765_43A1, rd, er, lat);
    total++;
    if (rd !== 32'd0 || er !== 1'b0 || lat != 2) begin
      bad++; $display("FAIL sw_0x100: rdata=%h err=%b lat=%0d want 0/0/2", rd, er, lat);
    end
    d_op(1'b0, 3'd0, 32'h100, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFF_FFA1 || er !== 1'b0 || lat != 2) begin
      bad++; $display("FAIL lb_0x100: rdata=%h err=%b lat=%0d want ffffffa1/0/2", rd, er, lat);
    end
    @(posedge clk); #1;
    total++;
    if (d_rv !== 1'b0) begin bad++; $display("FAIL rsp_pulse: d_rsp_valid=%b want 0", d_rv); end
    m_data(1'b1, 3'd0, 32'h101, 32'h0000_0055, mrd, mer);
    d_op(1'b1, 3'd0, 32'h101, 32'h0000_0055, rd, er, lat);
    d_op(1'b0, 3'd2, 32'h100, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'h8765_55A1 || er !== 1'b0) begin
      bad++; $display("FAIL lw_after_sb: rdata=%h err=%b want 876555a1/0", rd, er);
    end
    d_op(1'b0, 3'd5, 32'h102, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'h0000_8765 || er !== 1'b0 || lat != 2) begin
      bad++; $display("FAIL lhu_0x102: rdata=%h err=%b lat=%0d want 00008765/0/2", rd, er, lat);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] rd, mrd; logic er, mer; int lat;
    sel = 1'b0;
    m_data(1'b1, 3'd2, 32'h0, 32'h1111_2222, mrd, mer);
    d_op(1'b1, 3'd2, 32'h0, 32'h1111_2222, rd, er, lat);
    m_data(1'b1, 3'd2, 32'h4, 32'h3333_4444, mrd, mer);
    d_op(1'b1, 3'd2, 32'h4, 32'h3333_4444, rd, er, lat);
    d_op(1'b0, 3'd2, 32'h4, 32'd0, rd, er, lat);
    f_op(32'h2, rd, er, lat);
    total++;
    if (rd !== 32'h4444_1111 || er !== 1'b0 || lat != 3) begin
      bad++; $display("FAIL fetch_split: rdata=%h err=%b lat=%0d want 44441111/0/3", rd, er, lat);
    end
    f_op(32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h1111_2222 || er !== 1'b0 || lat != 2) begin
      bad++; $display("FAIL fetch_word: rdata=%h err=%b lat=%0d want 11112222/0/2", rd, er, lat);
    end
    total++;
    if (d_rd !== 32'h3333_4444 || d_er !== 1'b0) begin
      bad++; $display("FAIL d_hold: d_rdata=%h d_err=%b want 33334444/0", d_rd, d_er);
    end
  endtask

  task automatic test_errors;
    logic        dwe [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  df3 [8] = '{3'd2, 3'd1, 3'd3, 3'd7, 3'd4, 3'd2, 3'd0, 3'd5};
    logic [31:0] dea [8] = '{32'h102, 32'h103, 32'h100, 32'h100, 32'h100, 32'h4000, 32'h4000, 32'h101};
    logic [31:0] fa  [4] = '{32'h1, 32'h3FFE, 32'h4000, 32'hFFFF_FFF0};
    logic [31:0] rd; logic er; int lat;
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_op(dwe[i], df3[i], dea[i], $urandom, rd, er, lat);
      total++;
      if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin
        bad++; $display("FAIL d_err_case%0d: err=%b rdata=%h lat=%0d want 1/0/1", i, er, rd, lat);
      end
    end
    for (int i = 0; i < 4; i++) begin
      f_op(fa[i], rd, er, lat);
      total++;
      if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin
        bad++; $display("FAIL if_err_case%0d: err=%b rdata=%h lat=%0d want 1/0/1", i, er, rd, lat);
      end
    end
    d_op(1'b0, 3'd2, 32'h100, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'h8765_55A1 || er !== 1'b0) begin
      bad++; $display("FAIL ram_unchanged: rdata=%h err=%b want 876555a1/0", rd, er);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, mrd, ea, wd; logic er, mer, we; logic [2:0] f3; int lat, mlat;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      m_data(1'b1, 3'd2, 32'h200 + 4*i, wd, mrd, mer);
      d_op(1'b1, 3'd2, 32'h200 + 4*i, wd, rd, er, lat);
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ea = 32'h200 + 2*$urandom_range(0, 29) + (($urandom_range(0, 5) == 0) ? 1 : 0);
        m_fetch(ea, 0, mrd, mer, mlat);
        f_op(ea, rd, er, lat);
        total++;
        if (rd !== mrd || er !== mer || lat != mlat) begin
          bad++; $display("FAIL rnd_fetch%0d a=%h: rdata=%h err=%b lat=%0d want %h/%b/%0d", i, ea, rd, er, lat, mrd, mer, mlat);
        end
      end else begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        ea = 32'h200 + $urandom_range(0, 63);
        wd = $urandom;
        m_data(we, f3, ea, wd, mrd, mer);
        mlat = mer ? 1 : 2;
        d_op(we, f3, ea, wd, rd, er, lat);
        total++;
        if (rd !== mrd || er !== mer || lat != mlat) begin
          bad++; $display("FAIL rnd_data%0d we=%b f3=%0d ea=%h: rdata=%h err=%b lat=%0d want %h/%b/%0d",
                          i, we, f3, ea, rd, er, lat, mrd, mer, mlat);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int got [4];
    int grants, cyc, exp_g;
    bit last_data;
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    if_addr = 32'h0; if_v = 1'b1;
    d_we = 1'b0; d_f3 = 3'd2; d_addr = 32'h100 - 32'd48; d_v = 1'b1;
    grants = 0; cyc = 0;
    while (grants < 4 && cyc < 60) begin
      #1;
      total++;
      if (if_rdy && d_rdy) begin bad++; $display("FAIL dual_ready: both readies high at cycle %0d", cyc); end
      if (if_rdy) begin got[grants] = 0; grants++; end
      else if (d_rdy) begin got[grants] = 1; grants++; end
      @(negedge clk); cyc++;
    end
    if_v = 1'b0; d_v = 1'b0;
    total++;
    if (grants != 4) begin
      bad++; $display("FAIL rr_grants: saw %0d grants want 4", grants);
    end else begin
      last_data = 1'b1;
      for (int i = 0; i < 4; i++) begin
        exp_g = last_data ? 0 : 1;
        last_data = (exp_g == 1);
        total++;
        if (got[i] != exp_g) begin
          bad++; $display("FAIL rr_order%0d: granted %0d want %0d (0=fetch 1=data)", i, got[i], exp_g);
        end
      end
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_latency3_reset;
    logic [31:0] rd; logic er; int lat; int stray;
    sel = 1'b1;
    d_op(1'b1, 3'd2, 32'h40, 32'hA5A5_A5A5, rd, er, lat);
    total++;
    if (lat != 5 || er !== 1'b0) begin bad++; $display("FAIL l3_sw_lat: lat=%0d err=%b want 5/0", lat, er); end
    d_op(1'b1, 3'd2, 32'h44, 32'h0BAD_F00D, rd, er, lat);
    d_op(1'b0, 3'd2, 32'h40, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'hA5A5_A5A5 || lat != 5) begin
      bad++; $display("FAIL l3_lw: rdata=%h lat=%0d want a5a5a5a5/5", rd, lat);
    end
    f_op(32'h42, rd, er, lat);
    total++;
    if (rd !== 32'hF00D_A5A5 || er !== 1'b0 || lat != 9) begin
      bad++; $display("FAIL l3_split: rdata=%h err=%b lat=%0d want f00da5a5/0/9", rd, er, lat);
    end
    @(negedge clk);
    d_we = 1'b1; d_f3 = 3'd2; d_addr = 32'h40 - 32'd48; d_wdata = 32'h1234_5678; d_v = 1'b1;
    #1;
    total++;
    if (d_rdy !== 1'b1) begin bad++; $display("FAIL l3_arm: d_req_ready=%b want 1", d_rdy); end
    @(posedge clk); #1; d_v = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({if_rdy, if_rv, if_er, d_rdy, d_rv, d_er} !== 6'b0 || if_rd !== 32'd0 || d_rd !== 32'd0) begin
      bad++; $display("FAIL l3_reset_outs: ctl=%b if_rdata=%h d_rdata=%h want 0",
                      {if_rdy, if_rv, if_er, d_rdy, d_rv, d_er}, if_rd, d_rd);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    repeat (12) begin @(posedge clk); #1; if (d_rv || if_rv) stray++; end
    total++;
    if (stray != 0) begin bad++; $display("FAIL l3_no_rsp: %0d stray responses want 0", stray); end
    d_op(1'b0, 3'd2, 32'h40, 32'd0, rd, er, lat);
    total++;
    if (rd !== 32'hA5A5_A5A5 || er !== 1'b0 || lat != 5) begin
      bad++; $display("FAIL l3_after_reset: rdata=%h err=%b lat=%0d want a5a5a5a5/0/5", rd, er, lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_fetch();
    test_errors();
    test_random();
    test_back_to_back();
    test_latency3_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
